// File: rtl/serial_traffic_gen_if.sv
// Serial link between a traffic source and a router local port.
// The source drives data; the router drives busy back.
interface serial_traffic_gen_if;
   logic data;
   logic busy;

   modport master (output data, input busy);
   modport slave  (input data, output busy);
endinterface

// File: rtl/serial_traffic_gen.sv
// Serial frame source: start bit, destination, payload (LSB first),
// with selectable destination pattern, idle gap and packet limit.
module serial_traffic_gen #(
   parameter int          SRC_ID     = 0,
   parameter int          NUM_NODES  = 16,
   parameter int          ADDR_W     = 4,
   parameter int          PAYLOAD_W  = 8,
   parameter int          MODE       = 0,
   parameter int          FIXED_DEST = 0,
   parameter int          MAX_PKTS   = 0,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_traffic_gen_if.master  link,
   input  logic                  enable,
   input  logic [7:0]            rate,
   output logic [15:0]           pkt_count,
   output logic                  done
);
   localparam int FW = ADDR_W + PAYLOAD_W;
   localparam int L  = 1 + FW;
   localparam int CW = $clog2(L);
   localparam int H  = ADDR_W / 2;

   localparam logic [ADDR_W-1:0] SRC = ADDR_W'(SRC_ID);
   localparam logic [ADDR_W-1:0] FIX = ADDR_W'(FIXED_DEST);
   localparam logic [ADDR_W-1:0] TRN = {SRC[H-1:0], SRC[ADDR_W-1:H]};
   localparam logic [15:0]       LIM = 16'(MAX_PKTS);
   localparam logic [CW-1:0]     TOP = CW'(L - 1);

   typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_t;

   state_t            state;
   logic [7:0]        gap_cnt;
   logic [15:0]       lfsr;
   logic [15:0]       lfsr_nxt;
   logic [15:0]       cnt_nxt;
   logic [ADDR_W-1:0] rr_ptr;
   logic [ADDR_W-1:0] rr_nxt;
   logic [ADDR_W-1:0] dest;
   logic [FW-1:0]     shreg;
   logic [CW-1:0]     bit_cnt;
   logic              start;

   always_comb begin
      lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      rr_nxt = (int'(rr_ptr) == NUM_NODES - 1) ? '0 : rr_ptr + ADDR_W'(1);
      if (rr_nxt == SRC)
         rr_nxt = (int'(rr_nxt) == NUM_NODES - 1) ? '0 : rr_nxt + ADDR_W'(1);
      dest = FIX;
      unique case (1'b1)
         (MODE == 1): dest = rr_nxt;
         (MODE == 2): dest = lfsr_nxt[ADDR_W-1:0];
         (MODE == 3): dest = TRN;
         default:     dest = FIX;
      endcase
      cnt_nxt = pkt_count + 16'd1;
      // The cycle the gap counter runs out doubles as the idle decision.
      start = enable && !link.busy &&
              (state == IDLE || (state == GAP && gap_cnt <= 8'd1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         link.data <= 1'b0;
         pkt_count <= '0;
         done      <= 1'b0;
         gap_cnt   <= '0;
         lfsr      <= SEED;
         rr_ptr    <= SRC;
         shreg     <= '0;
         bit_cnt   <= '0;
      end else if (start) begin
         state     <= SEND;
         link.data <= 1'b1;
         shreg     <= {PAYLOAD_W'(pkt_count), dest};
         bit_cnt   <= TOP;
         gap_cnt   <= '0;
         lfsr      <= lfsr_nxt;
         rr_ptr    <= rr_nxt;
      end else begin
         unique case (state)
            IDLE: ;
            GAP: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt <= 8'd1)
                  state <= IDLE;
            end
            SEND: begin
               if (bit_cnt == '0) begin
                  link.data <= 1'b0;
                  pkt_count <= cnt_nxt;
                  if (MAX_PKTS != 0 && cnt_nxt == LIM) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= (rate == 8'd0) ? 8'd1 : rate;
                  end
               end else begin
                  link.data <= shreg[0];
                  shreg     <= shreg >> 1;
                  bit_cnt   <= bit_cnt - CW'(1);
               end
            end
            DONE: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_traffic_gen.sv
// Bench for serial_traffic_gen: five instances covering all modes,
// a frame-level reference model plus directed literal checks.
module tb_serial_traffic_gen;
   localparam int NI = 5;
   localparam int AW  [NI] = '{4, 2, 4, 4, 4};
   localparam int SRC [NI] = '{0, 3, 6, 5, 0};
   localparam int MD  [NI] = '{0, 1, 3, 3, 2};
   localparam int FX  [NI] = '{5, 0, 0, 0, 0};
   localparam int MX  [NI] = '{0, 0, 0, 0, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] rst_n;
   logic [NI-1:0] en;
   logic [NI-1:0] bsy;
   logic [NI-1:0] d;
   logic [NI-1:0] dn;
   logic [7:0]    rate [NI];
   logic [15:0]   pc   [NI];

   int vec = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   serial_traffic_gen_if i0 ();
   serial_traffic_gen_if i1 ();
   serial_traffic_gen_if i2 ();
   serial_traffic_gen_if i3 ();
   serial_traffic_gen_if i4 ();
   assign i0.busy = bsy[0];
   assign i1.busy = bsy[1];
   assign i2.busy = bsy[2];
   assign i3.busy = bsy[3];
   assign i4.busy = bsy[4];
   assign d[0] = i0.data;
   assign d[1] = i1.data;
   assign d[2] = i2.data;
   assign d[3] = i3.data;
   assign d[4] = i4.data;

   serial_traffic_gen #(.SRC_ID(0), .NUM_NODES(16), .ADDR_W(4),
      .PAYLOAD_W(8), .MODE(0), .FIXED_DEST(5), .MAX_PKTS(0),
      .SEED(16'hACE1)) u0 (.clk(clk), .reset(rst_n[0]), .link(i0),
      .enable(en[0]), .rate(rate[0]), .pkt_count(pc[0]), .done(dn[0]));
   serial_traffic_gen #(.SRC_ID(3), .NUM_NODES(4), .ADDR_W(2),
      .PAYLOAD_W(8), .MODE(1), .FIXED_DEST(0), .MAX_PKTS(0),
      .SEED(16'hACE1)) u1 (.clk(clk), .reset(rst_n[1]), .link(i1),
      .enable(en[1]), .rate(rate[1]), .pkt_count(pc[1]), .done(dn[1]));
   serial_traffic_gen #(.SRC_ID(6), .NUM_NODES(16), .ADDR_W(4),
      .PAYLOAD_W(8), .MODE(3), .FIXED_DEST(0), .MAX_PKTS(0),
      .SEED(16'hACE1)) u2 (.clk(clk), .reset(rst_n[2]), .link(i2),
      .enable(en[2]), .rate(rate[2]), .pkt_count(pc[2]), .done(dn[2]));
   serial_traffic_gen #(.SRC_ID(5), .NUM_NODES(16), .ADDR_W(4),
      .PAYLOAD_W(8), .MODE(3), .FIXED_DEST(0), .MAX_PKTS(0),
      .SEED(16'hACE1)) u3 (.clk(clk), .reset(rst_n[3]), .link(i3),
      .enable(en[3]), .rate(rate[3]), .pkt_count(pc[3]), .done(dn[3]));
   serial_traffic_gen #(.SRC_ID(0), .NUM_NODES(16), .ADDR_W(4),
      .PAYLOAD_W(8), .MODE(2), .FIXED_DEST(0), .MAX_PKTS(3),
      .SEED(16'hACE1)) u4 (.clk(clk), .reset(rst_n[4]), .link(i4),
      .enable(en[4]), .rate(rate[4]), .pkt_count(pc[4]), .done(dn[4]));

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   // Reference model: frame contents and start timing per instance.
   int          m_rem  [NI];
   int          m_z    [NI];
   int          m_g    [NI];
   int          m_rr   [NI];
   bit          m_elig [NI];
   bit          m_done [NI];
   logic [15:0] m_cnt  [NI];
   logic [15:0] m_lfsr [NI];
   logic [31:0] m_bits [NI];
   logic        ed;
   bit          last;
   int          dst;

   function automatic int pick_dest(input int i);
      int n, h, r;
      n = 1 << AW[i];
      h = AW[i] / 2;
      case (MD[i])
         0: r = FX[i] % n;
         1: begin
            m_rr[i] = (m_rr[i] + 1) % n;
            if (m_rr[i] == SRC[i]) m_rr[i] = (m_rr[i] + 1) % n;
            r = m_rr[i];
         end
         2: begin
            m_lfsr[i] = lfsr_step(m_lfsr[i]);
            r = int'(m_lfsr[i]) % n;
         end
         default: r = ((SRC[i] % (1 << h)) << h) | (SRC[i] >> h);
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n[i]) begin
            chk("rst_data", i, 32'(d[i]), 0);
            chk("rst_pc", i, 32'(pc[i]), 0);
            chk("rst_done", i, 32'(dn[i]), 0);
            m_rem[i] = 0;
            m_cnt[i] = '0;
            m_done[i] = 1'b0;
            m_elig[i] = 1'b1;
            m_z[i] = 0;
            m_g[i] = 1;
            m_lfsr[i] = 16'hACE1;
            m_rr[i] = SRC[i];
         end else begin
            ed = 1'b0;
            last = 1'b0;
            if (m_rem[i] > 0) begin
               ed = m_bits[i][0];
               m_bits[i] = m_bits[i] >> 1;
               m_rem[i]--;
               last = (m_rem[i] == 0);
            end
            chk("data", i, 32'(d[i]), 32'(ed));
            chk("pc", i, 32'(pc[i]), 32'(m_cnt[i]));
            chk("done", i, 32'(dn[i]), 32'(m_done[i]));
            if (last) begin
               m_cnt[i] = m_cnt[i] + 16'd1;
               m_g[i] = (rate[i] == 8'd0) ? 1 : int'(rate[i]);
               m_z[i] = 0;
               m_elig[i] = 1'b0;
               if (MX[i] != 0 && int'(m_cnt[i]) == MX[i]) m_done[i] = 1'b1;
            end else if (m_rem[i] == 0) begin
               m_z[i]++;
               if (m_z[i] >= m_g[i]) m_elig[i] = 1'b1;
               if (m_elig[i] && en[i] && !bsy[i] && !m_done[i]) begin
                  dst = pick_dest(i);
                  m_bits[i] = 32'd1 | (32'(dst) << 1) |
                              (32'(m_cnt[i] & 16'hFF) << (1 + AW[i]));
                  m_rem[i] = 1 + AW[i] + 8;
                  m_elig[i] = 1'b0;
               end
            end
         end
      end
   end

   // Frame capture from the serial line.
   int          mon_in  [NI];
   int          zrun    [NI];
   int          nf      [NI];
   int          nstart  [NI];
   int          st_cyc  [NI];
   logic [31:0] mon_sh  [NI];
   int          cap_dst [NI][32];
   int          cap_pay [NI][32];
   int          cap_gap [NI][32];

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n[i]) begin
            mon_in[i] = 0;
            zrun[i] = 0;
         end else if (mon_in[i] > 0) begin
            mon_sh[i][mon_in[i] - 1] = d[i];
            mon_in[i]++;
            if (mon_in[i] == 1 + AW[i] + 8) begin
               if (nf[i] < 32) begin
                  cap_dst[i][nf[i]] = int'(mon_sh[i]) & ((1 << AW[i]) - 1);
                  cap_pay[i][nf[i]] = int'(mon_sh[i] >> AW[i]) & 255;
               end
               nf[i]++;
               mon_in[i] = 0;
            end
         end else if (d[i]) begin
            if (nstart[i] < 32) cap_gap[i][nstart[i]] = zrun[i];
            nstart[i]++;
            st_cyc[i] = cyc;
            mon_in[i] = 1;
            mon_sh[i] = '0;
            zrun[i] = 0;
         end else begin
            zrun[i]++;
         end
      end
   end

   task automatic wait_nf(input int i, input int n, input string nm);
      int k;
      k = 0;
      while (nf[i] < n && k < 600) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(nm, i, 32'(nf[i] >= n), 1);
   endtask

   task automatic wait_start(input int i, input int n, input string nm);
      int k;
      k = 0;
      while (nstart[i] < n && k < 600) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(nm, i, 32'(nstart[i] >= n), 1);
   endtask

   int ns0, nf0, fall, k4;
   initial begin
      for (int i = 0; i < NI; i++) begin
         nf[i] = 0;
         nstart[i] = 0;
         mon_in[i] = 0;
         zrun[i] = 0;
      end
      rst_n = '1;
      en = '1;
      bsy = '0;
      rate[0] = 8'd3;
      rate[1] = 8'd1;
      rate[2] = 8'd2;
      rate[3] = 8'd2;
      rate[4] = 8'd0;
      #2 rst_n = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = '1;

      // Fixed destination, rate 3.
      wait_nf(0, 2, "m0_to");
      @(negedge clk);
      chk("m0_pc2", 0, 32'(pc[0]), 2);
      chk("m0_dst0", 0, cap_dst[0][0], 5);
      chk("m0_pay0", 0, cap_pay[0][0], 0);
      chk("m0_dst1", 0, cap_dst[0][1], 5);
      chk("m0_pay1", 0, cap_pay[0][1], 1);
      chk("m0_gap", 0, cap_gap[0][1], 3);

      // Busy raised mid-frame, held 40 cycles.
      wait_start(0, nstart[0] + 1, "busy_s_to");
      repeat (3) @(posedge clk);
      #1 bsy[0] = 1'b1;
      ns0 = nstart[0];
      nf0 = nf[0];
      repeat (40) @(posedge clk);
      #1;
      chk("busy_nostart", 0, nstart[0], ns0);
      chk("busy_intact", 0, nf[0], nf0 + 1);
      bsy[0] = 1'b0;
      fall = cyc;
      wait_start(0, ns0 + 1, "busy_to");
      chk("busy_lat", 0, st_cyc[0], fall + 1);

      // Round-robin and transpose destinations.
      wait_nf(1, 6, "rr_to");
      chk("rr0", 1, cap_dst[1][0], 0);
      chk("rr1", 1, cap_dst[1][1], 1);
      chk("rr2", 1, cap_dst[1][2], 2);
      chk("rr3", 1, cap_dst[1][3], 0);
      chk("rr4", 1, cap_dst[1][4], 1);
      chk("rr5", 1, cap_dst[1][5], 2);
      wait_nf(2, 3, "tr6_to");
      wait_nf(3, 3, "tr5_to");
      for (int k = 0; k < 3; k++) begin
         chk("tr6", 2, cap_dst[2][k], 9);
         chk("tr5", 3, cap_dst[3][k], 5);
      end

      // Packet limit with rate 0, LFSR destinations.
      wait_nf(4, 3, "lim_to");
      repeat (20) @(posedge clk);
      #1;
      chk("lim_done", 4, 32'(dn[4]), 1);
      chk("lim_frames", 4, nstart[4], 3);
      chk("lim_pc", 4, 32'(pc[4]), 3);
      chk("lim_gap1", 4, cap_gap[4][1], 1);
      chk("lim_gap2", 4, cap_gap[4][2], 1);
      chk("lfsr_d0", 4, cap_dst[4][0], 0);
      chk("lfsr_d1", 4, cap_dst[4][1], 8);
      chk("lfsr_d2", 4, cap_dst[4][2], 12);
      chk("lim_pay2", 4, cap_pay[4][2], 2);

      // Asynchronous reset out of DONE, then mid-frame during bit 4.
      rst_n[4] = 1'b0;
      #1;
      chk("ar_done", 4, 32'(dn[4]), 0);
      chk("ar_pc", 4, 32'(pc[4]), 0);
      @(posedge clk);
      #1 rst_n[4] = 1'b1;
      wait_start(4, 5, "ar_s_to");
      repeat (4) @(posedge clk);
      #1;
      chk("bit4_hi", 4, 32'(d[4]), 1);
      chk("bit4_pc", 4, 32'(pc[4]), 1);
      rst_n[4] = 1'b0;
      #1;
      chk("mid_data", 4, 32'(d[4]), 0);
      chk("mid_pc", 4, 32'(pc[4]), 0);
      chk("mid_done", 4, 32'(dn[4]), 0);
      @(posedge clk);
      #1 rst_n[4] = 1'b1;
      k4 = nf[4];
      wait_nf(4, k4 + 1, "post_to");
      chk("post_dst", 4, cap_dst[4][k4], 0);
      chk("post_pay", 4, cap_pay[4][k4], 0);

      // Rate change and enable drop mid-frame.
      rate[0] = 8'd0;
      wait_start(0, nstart[0] + 2, "r0_to");
      repeat (5) @(posedge clk);
      #1;
      en[0] = 1'b0;
      rate[0] = 8'd5;
      ns0 = nstart[0];
      repeat (40) @(posedge clk);
      #1;
      chk("en_off", 0, nstart[0], ns0);
      en[0] = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("en_on", 0, 32'(nstart[0] > ns0), 1);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
